// File: rtl/bram_port_arbiter.sv
// Two-requester BRAM port arbiter: round-robin burst grants with a one-cycle gap
// between bursts. All handshake and BRAM-side outputs come straight from flops.
module bram_port_arbiter #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [LEN_W-1:0]  len_a,
  input  logic [LEN_W-1:0]  len_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              done_a,
  output logic              done_b,
  output logic              sel,
  output logic [ADDR_W-1:0] addr_bram,
  output logic              ena_bram,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StBurst, StGap} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic                sel_q, sel_d;
  logic                last_q, last_d;   // 1 = B owned the previous burst
  logic                gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic                done_a_q, done_a_d, done_b_q, done_b_d;
  logic                ena_q, ena_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                pick_b;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    beat_d   = beat_q;
    sel_d    = sel_q;
    last_d   = last_q;
    addr_d   = addr_q;
    gnt_a_d  = 1'b0;
    gnt_b_d  = 1'b0;
    done_a_d = 1'b0;
    done_b_d = 1'b0;
    ena_d    = 1'b0;
    // On a tie, B wins only if A owned the previous burst
    pick_b   = req_b & (~req_a | ~last_q);

    unique case (state_q)
      StIdle: begin
        if (req_a || req_b) begin
          state_d  = StBurst;
          sel_d    = pick_b;
          last_d   = pick_b;
          base_d   = pick_b ? base_b : base_a;
          len_d    = pick_b ? len_b : len_a;
          beat_d   = '0;
          ena_d    = 1'b1;
          addr_d   = base_d;
          gnt_a_d  = ~pick_b;
          gnt_b_d  = pick_b;
          done_a_d = (len_d == '0) & ~pick_b;
          done_b_d = (len_d == '0) & pick_b;
        end
      end
      StBurst: begin
        if (beat_q == len_q) begin
          state_d = StGap;
          beat_d  = '0;
        end else begin
          beat_d   = beat_q + LEN_W'(1);
          ena_d    = 1'b1;
          addr_d   = base_q + ADDR_W'(beat_d);
          gnt_a_d  = ~sel_q;
          gnt_b_d  = sel_q;
          done_a_d = (beat_d == len_q) & ~sel_q;
          done_b_d = (beat_d == len_q) & sel_q;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      base_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      ena_q    <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
      ena_q    <= ena_d;
      addr_q   <= addr_d;
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign done_a    = done_a_q;
  assign done_b    = done_b_q;
  assign sel       = sel_q;
  assign addr_bram = addr_q;
  assign ena_bram  = ena_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: expected beats are queued when a burst is
// requested and compared on every cycle the BRAM enable is high.
module tb_bram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [8:0] base_a = '0, base_b = '0;
  logic [8:0] len_a = '0, len_b = '0;
  logic       gnt_a, gnt_b, done_a, done_b, sel, ena_bram, busy;
  logic [8:0] addr_bram;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          mon_en = 1'b0;

  // {gnt_a, gnt_b, sel, done_a, done_b, addr}
  logic [13:0] exp_q[$];

  bram_port_arbiter #(.ADDR_W(9), .LEN_W(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .req_b     (req_b),
    .base_a    (base_a),
    .base_b    (base_b),
    .len_a     (len_a),
    .len_b     (len_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .done_a    (done_a),
    .done_b    (done_b),
    .sel       (sel),
    .addr_bram (addr_bram),
    .ena_bram  (ena_bram),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_burst(input bit own_b, input logic [8:0] base, input int len);
    for (int i = 0; i <= len; i++) begin
      logic [8:0] a;
      logic       last;
      a    = base + 9'(i);
      last = (i == len);
      exp_q.push_back({~own_b, own_b, own_b, last & ~own_b, last & own_b, a});
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  always @(negedge clk) begin : monitor
    logic [13:0] e;
    if (mon_en && rst_n) begin
      if (ena_bram) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", {gnt_a, gnt_b, sel, done_a, done_b, addr_bram}, 32'h3fff_0000);
        end else begin
          e = exp_q.pop_front();
          check("beat", {gnt_a, gnt_b, sel, done_a, done_b, addr_bram}, 32'(e));
        end
      end else begin
        check("idle_out", {gnt_a, gnt_b, done_a, done_b}, 32'd0);
      end
    end
  end

  initial begin
    int n;
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_gnt",  {gnt_a, gnt_b}, 0);
    check("rst_done", {done_a, done_b}, 0);
    check("rst_ena",  ena_bram, 0);
    check("rst_addr", addr_bram, 0);
    check("rst_sel",  sel, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Single burst from A, with first-beat latency
    @(negedge clk);
    base_a = 9'h010; len_a = 9'd3;
    push_burst(1'b0, 9'h010, 3);
    req_a = 1'b1;
    #1 check("pre_grant_ena", ena_bram, 0);
    @(posedge clk);
    #1 check("latency_ena", ena_bram, 1);
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    #1 check("busy_in_burst", busy, 1);
    wait_drain(20);
    check("sel_hold_a", sel, 0);

    // Tie after reset: A first, then B
    do_reset();
    base_a = 9'h020; len_a = 9'd2;
    base_b = 9'h100; len_b = 9'd1;
    push_burst(1'b0, 9'h020, 2);
    push_burst(1'b1, 9'h100, 1);
    req_a = 1'b1; req_b = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    n = 0;
    while (!gnt_b && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("gnt_b_timeout", 32'(n < 20), 1);
    req_b = 1'b0;
    wait_drain(20);
    check("sel_hold_b", sel, 1);

    // Address wrap
    @(negedge clk);
    base_a = 9'h1FE; len_a = 9'd3;
    push_burst(1'b0, 9'h1FE, 3);
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    wait_drain(20);

    // Early request drop with base/len changed mid-burst
    @(negedge clk);
    base_a = 9'h030; len_a = 9'd5;
    push_burst(1'b0, 9'h030, 5);
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    base_a = 9'h155; len_a = 9'd0;
    wait_drain(30);

    // Mid-burst reset during beat 2: no done, outputs cleared immediately
    @(negedge clk);
    base_a = 9'h040; len_a = 9'd5;
    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h040});
    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h041});
    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h042});
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 check("beats_before_rst", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_outs",
          {gnt_a, gnt_b, done_a, done_b, ena_bram, busy, sel, addr_bram}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    base_b = 9'h100; len_b = 9'd1;
    push_burst(1'b1, 9'h100, 1);
    req_b = 1'b1;
    @(negedge clk);
    req_b = 1'b0;
    wait_drain(20);

    // Fairness with both requests held, single-beat bursts
    do_reset();
    base_a = 9'h0A0; len_a = 9'd0;
    base_b = 9'h0B0; len_b = 9'd0;
    for (int i = 0; i < 3; i++) begin
      push_burst(1'b0, 9'h0A0, 0);
      push_burst(1'b1, 9'h0B0, 0);
    end
    req_a = 1'b1; req_b = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("fair_timeout", 32'(n < 40), 1);
    req_a = 1'b0; req_b = 1'b0;
    wait_drain(20);
    check("fair_last_sel", sel, 1);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 9, BRAM address width; LEN_W, 9, burst-length field width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_a / req_b  in  1  burst request from requester A / B.
REQ-005 base_a / base_b  in  ADDR_W  burst start address for A / B.
REQ-006 len_a / len_b  in  LEN_W  burst beats minus one for A / B (0 = one beat).
REQ-007 gnt_a / gnt_b  out  1  requester owns the BRAM port for the current beat.
REQ-008 done_a / done_b  out  1  one-cycle pulse on the final beat of the burst.
REQ-009 sel  out  1  port select to the BRAM mux (0 = A, 1 = B).
REQ-010 addr_bram  out  ADDR_W  BRAM address.
REQ-011 ena_bram  out  1  BRAM enable.
REQ-012 busy  out  1  high while state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, BURST and GAP.
REQ-014 IDLE, no request: remain in IDLE; ena_bram=0; gnt_*=0.
REQ-015 IDLE, exactly one req high: grant that requester; capture its base and len into internal registers; beat counter=0; next state BURST.
REQ-016 IDLE, both req high: grant the requester that is not last_owner (round robin).
REQ-017 last_owner SHALL update to the granted requester at grant time.
REQ-018 Latency: request sampled in IDLE at edge N; first beat is driven in the cycle after edge N.
REQ-019 BURST: ena_bram=1; addr_bram = captured base + beat, modulo 2^ADDR_W (wraps 0x1FF -> 0x000 at ADDR_W=9).
REQ-020 BURST: gnt of the owner=1; gnt of the other requester=0; sel = owner.
REQ-021 BURST: beat increments by one each cycle.
REQ-022 BURST, beat == captured len: assert done of the owner for that cycle only; next state GAP.
REQ-023 GAP: exactly one cycle; ena_bram=0; gnt_*=0; next state IDLE.
REQ-024 sel SHALL hold its last value in IDLE and GAP; it changes only at grant.
REQ-025 req deassertion during BURST SHALL be ignored; the burst completes its full len+1 beats.
REQ-026 base and len changes during BURST SHALL be ignored; the captured values apply.
REQ-027 A requester still requesting in IDLE after its own burst SHALL be treated as a new request, subject to round robin.
REQ-028 gnt_*, done_*, ena_bram and addr_bram SHALL be registered outputs, glitch-free.
REQ-029 The beat counter SHALL be LEN_W bits wide; len = 2^LEN_W-1 gives a full-length burst with no overflow.

Reset
REQ-030 rst_n low SHALL immediately force:
- state IDLE;
- gnt_*=0, done_*=0, ena_bram=0, addr_bram=0, sel=0, busy=0;
- beat=0;
- last_owner=B, so A wins the first tie.
REQ-031 Reset asserted mid-burst SHALL abort the burst with no done pulse; operation resumes from IDLE on the first edge after rst_n rises.

Verification
REQ-032 Single burst: A alone, base_a=0x010, len_a=3 -> sel=0; ena_bram high 4 cycles; addr 0x010, 0x011, 0x012, 0x013; done_a on the 0x013 beat; then GAP and IDLE.
REQ-033 Tie after reset: req_a and req_b rise together (base_b=0x100, len_b=1) -> A burst first; then GAP, IDLE, B burst with sel=1, addr 0x100, 0x101, done_b.
REQ-034 Wrap: base_a=0x1FE, len_a=3 -> addr 0x1FE, 0x1FF, 0x000, 0x001.
REQ-035 Early drop: req_a dropped after the first beat of len_a=5 -> all 6 beats issued; done_a pulses once.
REQ-036 Mid-burst reset: rst_n pulsed low during beat 2 -> outputs zero asynchronously, no done; after release, a new req_b is granted, since last_owner=B makes A win ties only.
REQ-037 Fairness: req_a and req_b held high continuously, len=0 -> grants alternate A, B, A, B; sel toggles at each grant.
